// File: rtl/gate_truth_checker.sv
// Stimulus/verdict sequencer for a two-input gate: walks {A,B} through 00..11,
// samples C after SETTLE cycles and checks it against TRUTH. Option: GATE_CHK_STOP_ON_FAIL_EN.
module gate_truth_checker #(
   parameter logic [3:0]  TRUTH  = 4'b0001,
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       C,
   output logic       A,
   output logic       B,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_mask
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       ab_q, ab_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [2:0]       err_q, err_d;
   logic [3:0]       mask_q, mask_d;
   logic             mismatch_c;

   // C comes from a gate in this clock domain, so it is compared unsynchronised
   assign mismatch_c = (C != TRUTH[ab_q]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ab_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ab_q    <= ab_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ab_d    = ab_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;
      mask_d  = mask_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               ab_d    = 2'b00;
               cnt_d   = RELOAD;
               err_d   = '0;
               mask_d  = '0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else             state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            if (mismatch_c) begin
               mask_d = mask_q | (4'b0001 << ab_q);
               err_d  = err_q + 3'd1;
            end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
            if (mismatch_c || ab_q == 2'b11) begin
`else
            if (ab_q == 2'b11) begin
`endif
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               ab_d    = ab_q + 2'd1;
               cnt_d   = RELOAD;
               state_d = S_WAIT;
            end
         end
         S_DONE: begin
            // mask_q already holds the final SAMPLE update here
            pass_d  = (mask_q == 4'b0000);
            ab_d    = 2'b00;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign A         = ab_q[1];
   assign B         = ab_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Randomised self-checking bench for gate_truth_checker; the gate under test is a
// bench-side lookup table, and expectations come from a truth-table XOR model.
module tb_gate_truth_checker;

   localparam logic [3:0] NOR_TT = 4'b0001;
   localparam logic [3:0] AND_TT = 4'b1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start0 = 1'b0, start1 = 1'b0;
   logic [3:0] gate_tt = NOR_TT;

   logic a0, b0, busy0, done0, pass0, c0;
   logic a1, b1, busy1, done1, pass1, c1;
   logic [2:0] err0, err1;
   logic [3:0] mask0, mask1;

   int errors = 0;
   int checks = 0;
   int sel = 0;

   logic o_a, o_b, o_busy, o_done, o_pass;
   logic [2:0] o_err;
   logic [3:0] o_mask;

   always #5 clk = ~clk;

   assign c0 = gate_tt[{a0, b0}];
   assign c1 = gate_tt[{a1, b1}];

   gate_truth_checker dut0 (
      .clk(clk), .rst(rst), .start(start0), .C(c0), .A(a0), .B(b0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_mask(mask0)
   );

   gate_truth_checker #(.TRUTH(NOR_TT), .SETTLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .C(c1), .A(a1), .B(b1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_mask(mask1)
   );

   always_comb begin
      if (sel == 0) begin
         o_a = a0; o_b = b0; o_busy = busy0; o_done = done0; o_pass = pass0;
         o_err = err0; o_mask = mask0;
      end else begin
         o_a = a1; o_b = b1; o_busy = busy1; o_done = done1; o_pass = pass1;
         o_err = err1; o_mask = mask1;
      end
   end

   task automatic set_start(input logic v);
      if (sel == 0) start0 = v;
      else          start1 = v;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({a0, b0, busy0, done0, pass0, err0, mask0} !== 12'd0) begin
         errors++;
         $display("FAIL reset_dut0: got %b required 0", {a0, b0, busy0, done0, pass0, err0, mask0});
      end
      checks++;
      if ({a1, b1, busy1, done1, pass1, err1, mask1} !== 12'd0) begin
         errors++;
         $display("FAIL reset_dut1: got %b required 0", {a1, b1, busy1, done1, pass1, err1, mask1});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // One full run on instance `which` against gate table tt, checked against the model
   task automatic test_run(input int which, input int s, input logic [3:0] tt, input string name);
      logic [3:0] exp_mask;
      int exp_err, exp_done_cyc, t, ab_bad;
      bit done_seen;
      sel = which;
      gate_tt = tt;
      exp_mask = tt ^ NOR_TT;
      exp_err = $countones(exp_mask);
      exp_done_cyc = 4 * (s + 1) + 1;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
      for (int k = 0; k < 4; k++) begin
         if (exp_mask[k]) begin
            exp_mask = 4'b0001 << k;
            exp_err = 1;
            exp_done_cyc = (k + 1) * (s + 1) + 1;
            break;
         end
      end
`endif
      @(negedge clk);
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      t = 1; ab_bad = 0; done_seen = 0;
      while (!done_seen && t <= 80) begin
         if (o_done === 1'b1) begin
            done_seen = 1;
            checks++;
            if (t != exp_done_cyc) begin
               errors++;
               $display("FAIL %s done_cycle: got %0d required %0d", name, t, exp_done_cyc);
            end
            checks++;
            if (o_err !== 3'(exp_err)) begin
               errors++;
               $display("FAIL %s err_count: got %0d required %0d", name, o_err, exp_err);
            end
            checks++;
            if (o_mask !== exp_mask) begin
               errors++;
               $display("FAIL %s fail_mask: got %b required %b", name, o_mask, exp_mask);
            end
         end else begin
            if (o_busy !== 1'b1 || {o_a, o_b} !== 2'((t - 1) / (s + 1))) begin
               if (ab_bad == 0)
                  $display("FAIL %s ab_seq: cycle %0d got busy=%b ab=%b required busy=1 ab=%0d",
                           name, t, o_busy, {o_a, o_b}, (t - 1) / (s + 1));
               ab_bad++;
            end
            @(negedge clk);
            t++;
         end
      end
      checks++;
      if (!done_seen) begin
         errors++;
         $display("FAIL %s timeout: no done within 80 cycles, required cycle %0d", name, exp_done_cyc);
      end
      checks++;
      if (ab_bad != 0) errors++;
      @(negedge clk);
      checks++;
      if ({o_done, o_busy, o_a, o_b} !== 4'b0000) begin
         errors++;
         $display("FAIL %s after_done: got done,busy,a,b=%b required 0000", name, {o_done, o_busy, o_a, o_b});
      end
      checks++;
      if (o_pass !== (exp_mask == 4'b0000)) begin
         errors++;
         $display("FAIL %s pass: got %b required %b", name, o_pass, exp_mask == 4'b0000);
      end
   endtask

   // start held high: runs back to back, a second start while busy has no effect
   task automatic test_back_to_back();
      int done_cycles[$];
      int t;
      sel = 0;
      gate_tt = NOR_TT;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      for (t = 1; t <= 28; t++) begin
         if (done0 === 1'b1) done_cycles.push_back(t);
         if (t == 14) begin
            checks++;
            if (busy0 !== 1'b0 || pass0 !== 1'b1) begin
               errors++;
               $display("FAIL b2b_idle_gap: got busy=%b pass=%b required busy=0 pass=1", busy0, pass0);
            end
         end
         if (t == 8) begin
            checks++;
            if ({a0, b0} !== 2'b10) begin
               errors++;
               $display("FAIL b2b_ab_hold: got %b required 10", {a0, b0});
            end
         end
         @(negedge clk);
      end
      start0 = 1'b0;
      checks++;
      if (done_cycles.size() != 2 || done_cycles[0] != 13 || done_cycles[1] != 27) begin
         errors++;
         $display("FAIL b2b_done_cycles: got %0d pulses first=%0d required 2 pulses at 13,27",
                  done_cycles.size(), (done_cycles.size() > 0) ? done_cycles[0] : -1);
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      bit found;
      sel = 0;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
      gate_tt = 4'b0101;
`else
      gate_tt = AND_TT;
`endif
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      found = 0;
      for (int t = 0; t < 40 && !found; t++) begin
         if ({a0, b0} === 2'b10) found = 1;
         else @(negedge clk);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL mid_reset_reach10: got ab=%b required 10 within 40 cycles", {a0, b0});
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({a0, b0, busy0, done0, pass0, err0, mask0} !== 12'd0) begin
         errors++;
         $display("FAIL mid_reset_clear: got %b required 0", {a0, b0, busy0, done0, pass0, err0, mask0});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_run(0, 2, NOR_TT, "nor");
      test_run(0, 2, AND_TT, "and");
      test_run(0, 2, 4'b0000, "tied0");
      test_run(1, 1, NOR_TT, "settle1_nor");
      test_back_to_back();
      test_reset_mid_run();
      test_run(0, 2, NOR_TT, "after_reset");
      for (int i = 0; i < 6; i++) begin
         logic [3:0] tt;
         tt = 4'($urandom_range(0, 15));
         test_run(i % 2, (i % 2 == 0) ? 2 : 1, tt, "random");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
